stl_popcount_accum: RTL and testbench



---
 rtl/stl_popcount_pkg.sv | 20 ++
 rtl/StlPopcount.sv | 17 +
 rtl/stl_popcount_accum.sv | 182 ++++++++++++++++++
 tb/tb_stl_popcount_accum.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stl_popcount_pkg.sv
// Shared types and width helpers for the streaming popcount accumulator.
package stl_popcount_pkg;

  // Packet state: IDLE holds no partial sum, ACCUM holds one.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Bits needed to hold the ones-count of a single chunk (0..chunk_width).
  function automatic int chunk_cnt_width(input int chunk_width);
    return $clog2(chunk_width) + 1;
  endfunction

  // Bits needed to hold the ones-count of a full beat (0..input_width).
  function automatic int beat_cnt_width(input int input_width);
    return $clog2(input_width) + 1;
  endfunction

endpackage

// File: rtl/StlPopcount.sv
// Combinational population count of one word; result is 0..INPUT_WIDTH.
module StlPopcount #(
  parameter int INPUT_WIDTH = 16
) (
  input  logic [INPUT_WIDTH-1:0]       data_i,
  output logic [$clog2(INPUT_WIDTH):0] count_o
);

  // Sum every bit of the word, each zero-extended to the result width.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      count_o = count_o + {{$clog2(INPUT_WIDTH){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/stl_popcount_accum.sv
// Two-stage streaming popcount with masking, zeros mode and packet accumulation.
// Handshakes: a beat transfers on a cycle where in_valid_i & in_ready_o; a result
// transfers on a cycle where out_valid_o & out_ready_i. Valids never depend on the
// matching ready, and in_ready_o never depends on in_valid_i.
module stl_popcount_accum
  import stl_popcount_pkg::*;
#(
  parameter int INPUT_WIDTH = 64,
  parameter int CHUNK_WIDTH = 16,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INPUT_WIDTH-1:0] data_i,
  input  logic [INPUT_WIDTH-1:0] mask_i,
  input  logic                   invert_i,
  input  logic                   accum_en_i,
  input  logic                   last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_WIDTH-1:0]   count_o,
  output logic                   overflow_o,
  output state_e                 dbg_state_o
);

  localparam int NCHUNK = INPUT_WIDTH / CHUNK_WIDTH;
  localparam int CCW    = chunk_cnt_width(CHUNK_WIDTH);

  // Parameter legality checks at elaboration.
  if (INPUT_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_split
    $error("INPUT_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  if (CHUNK_WIDTH < 2 || (CHUNK_WIDTH & (CHUNK_WIDTH - 1)) != 0) begin : g_bad_chunk
    $error("CHUNK_WIDTH must be a power of two and at least 2");
  end
  if (ACC_WIDTH < beat_cnt_width(INPUT_WIDTH)) begin : g_bad_acc
    $error("ACC_WIDTH too small to hold a single beat count");
  end

  logic [INPUT_WIDTH-1:0]       w_eff;
  logic [NCHUNK-1:0][CCW-1:0]   w_chunk_cnt;
  logic                         w_accept;
  logic                         w_b_take;

  logic                         r_a_valid;
  logic [NCHUNK-1:0][CCW-1:0]   r_a_cnt;
  logic                         r_a_accum_en;
  logic                         r_a_last;

  state_e                       r_state;
  state_e                       w_state_n;
  logic [ACC_WIDTH-1:0]         r_acc;
  logic [ACC_WIDTH-1:0]         w_acc_n;
  logic                         r_ovf;
  logic                         w_ovf_n;

  logic [ACC_WIDTH-1:0]         w_beat;
  logic [ACC_WIDTH:0]           w_sum;
  logic [ACC_WIDTH-1:0]         w_sat;
  logic                         w_sat_ovf;
  logic                         w_emit;
  logic [ACC_WIDTH-1:0]         w_emit_cnt;
  logic                         w_emit_ovf;

  logic                         r_out_valid;
  logic [ACC_WIDTH-1:0]         r_out_cnt;
  logic                         r_out_ovf;

  assign w_eff      = (invert_i ? ~data_i : data_i) & mask_i;
  assign w_b_take   = r_a_valid & (~r_out_valid | out_ready_i);
  assign in_ready_o = ~r_a_valid | w_b_take;
  assign w_accept   = in_valid_i & in_ready_o;

  assign out_valid_o = r_out_valid;
  assign count_o     = r_out_cnt;
  assign overflow_o  = r_out_ovf;
  assign dbg_state_o = r_state;

  // Stage A counters: one popcount per chunk of the effective word.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    StlPopcount #(.INPUT_WIDTH(CHUNK_WIDTH)) u_pc (
      .data_i  (w_eff[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .count_o (w_chunk_cnt[g])
    );
  end

  // Stage A register: capture chunk counts and packet flags on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a_valid    <= 1'b0;
      r_a_cnt      <= '0;
      r_a_accum_en <= 1'b0;
      r_a_last     <= 1'b0;
    end else if (w_accept) begin
      r_a_valid    <= 1'b1;
      r_a_cnt      <= w_chunk_cnt;
      r_a_accum_en <= accum_en_i;
      r_a_last     <= last_i;
    end else if (w_b_take) begin
      r_a_valid    <= 1'b0;
    end
  end

  // Stage B reduction: beat count plus saturating add onto the partial sum.
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      w_beat = w_beat + ACC_WIDTH'(r_a_cnt[i]);
    end
    w_sum     = {1'b0, r_acc} + {1'b0, w_beat};
    w_sat_ovf = w_sum[ACC_WIDTH];
    w_sat     = w_sat_ovf ? '1 : w_sum[ACC_WIDTH-1:0];
  end

  // Packet FSM next state, accumulator update and emit decision.
  always_comb begin
    w_state_n  = r_state;
    w_acc_n    = r_acc;
    w_ovf_n    = r_ovf;
    w_emit     = 1'b0;
    w_emit_cnt = w_beat;
    w_emit_ovf = 1'b0;
    if (w_b_take) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_a_accum_en || r_a_last) begin
            w_emit = 1'b1;
          end else begin
            w_acc_n   = w_beat;
            w_ovf_n   = 1'b0;
            w_state_n = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_a_accum_en && !r_a_last) begin
            w_acc_n = w_sat;
            w_ovf_n = r_ovf | w_sat_ovf;
          end else begin
            w_emit     = 1'b1;
            w_emit_cnt = w_sat;
            w_emit_ovf = r_ovf | w_sat_ovf;
            w_acc_n    = '0;
            w_ovf_n    = 1'b0;
            w_state_n  = ST_IDLE;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  // Packet state, partial sum and sticky overflow registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_ovf   <= w_ovf_n;
    end
  end

  // Output register: load on emit, clear valid on handshake, otherwise hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_cnt   <= w_emit_cnt;
      r_out_ovf   <= w_emit_ovf;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stl_popcount_accum.sv
// Bench for stl_popcount_accum: a 24-bit and a 7-bit accumulator instance share
// one input stream so saturation is exercised alongside normal counting.
module tb_stl_popcount_accum;
  import stl_popcount_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [63:0] data     = '0;
  logic [63:0] mask     = '0;
  logic        invert   = 1'b0;
  logic        accum_en = 1'b0;
  logic        last     = 1'b0;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [23:0] count_a;
  state_e      dbg_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [6:0]  count_b;
  state_e      dbg_b;

  stl_popcount_accum #(.INPUT_WIDTH(64), .CHUNK_WIDTH(16), .ACC_WIDTH(24)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .data_i(data), .mask_i(mask), .invert_i(invert), .accum_en_i(accum_en),
    .last_i(last), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .count_o(count_a), .overflow_o(ovf_a), .dbg_state_o(dbg_a)
  );

  stl_popcount_accum #(.INPUT_WIDTH(64), .CHUNK_WIDTH(16), .ACC_WIDTH(7)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .data_i(data), .mask_i(mask), .invert_i(invert), .accum_en_i(accum_en),
    .last_i(last), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .count_o(count_b), .overflow_o(ovf_b), .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;
  // {ovf7, cnt7[6:0], ovf24, cnt24[23:0]}
  logic [32:0] exp_q[$];

  // Reference packet model: running exact total of the current packet.
  bit m_in_pkt = 1'b0;
  int m_sum    = 0;

  bit rand_ready = 1'b0;
  int stall_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // Saturation clamps every partial add, and sums only grow, so the result is
  // simply the exact packet total clamped at the accumulator maximum.
  task automatic push_exp(input int total);
    logic [23:0] c24;
    logic        o24;
    logic [6:0]  c7;
    logic        o7;
    o24 = (total > 16777215);
    c24 = o24 ? 24'hFF_FFFF : 24'(total);
    o7  = (total > 127);
    c7  = o7 ? 7'h7F : 7'(total);
    exp_q.push_back({o7, c7, o24, c24});
  endtask

  task automatic model_beat(input logic [63:0] d, input logic [63:0] m,
                            input logic inv, input logic ae, input logic lst);
    int beat;
    beat = $countones((inv ? ~d : d) & m);
    if (!m_in_pkt) begin
      if (!ae || lst) push_exp(beat);
      else begin
        m_in_pkt = 1'b1;
        m_sum    = beat;
      end
    end else begin
      m_sum += beat;
      if (!ae || lst) begin
        push_exp(m_sum);
        m_in_pkt = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a beat from a falling edge and hold it until the rising edge that accepts it.
  task automatic send(input logic [63:0] d, input logic [63:0] m,
                      input logic inv, input logic ae, input logic lst);
    int budget;
    budget = 0;
    @(negedge clk);
    data = d; mask = m; invert = inv; accum_en = ae; last = lst;
    in_valid = 1'b1;
    #1;
    while (!in_ready_a && budget < 200) begin
      budget++;
      @(negedge clk);
      #1;
    end
    if (!in_ready_a) begin
      fail_now("send_accept");
    end else begin
      model_beat(d, m, inv, ae, lst);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_a),  1);
    chk({tag, "_out_valid"}, 32'(out_valid_a), 0);
    chk({tag, "_count"},     32'(count_a),     0);
    chk({tag, "_ovf"},       32'(ovf_a),       0);
    chk({tag, "_state"},     32'(dbg_a),       32'(ST_IDLE));
    chk({tag, "_out_valid7"}, 32'(out_valid_b), 0);
  endtask

  // Result-side readiness: forced stall window, random backpressure or always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  logic        prev_stall    = 1'b0;
  logic        prev_in_valid = 1'b0;
  logic [23:0] prev_cnt      = '0;
  logic        prev_ovf      = 1'b0;

  always begin
    logic [32:0] e;
    logic        cur_stall;
    @(negedge clk);
    #4;
    if (rst) begin
      prev_stall    = 1'b0;
      prev_in_valid = 1'b0;
    end else begin
      cur_stall = out_valid_a && !out_ready;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid_a), 1);
        chk("hold_count", 32'(count_a), 32'(prev_cnt));
        chk("hold_ovf",   32'(ovf_a),   32'(prev_ovf));
      end
      if (cur_stall && prev_stall && prev_in_valid) begin
        chk("in_ready_stalled", 32'(in_ready_a), 0);
      end
      if (out_valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL unexpected_out: observed=%0d expected=none", count_a);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          chk("count24", 32'(count_a), 32'(e[23:0]));
          chk("ovf24",   32'(ovf_a),   32'(e[24]));
          chk("valid7",  32'(out_valid_b), 1);
          chk("count7",  32'(count_b), 32'(e[31:25]));
          chk("ovf7",    32'(ovf_b),   32'(e[32]));
        end
      end
      prev_stall    = cur_stall;
      prev_in_valid = in_valid;
      prev_cnt      = count_a;
      prev_ovf      = ovf_a;
    end
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] ones;
    logic [63:0] d, m;
    ones = '1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check_reset_state("rst0");

    // Single beat, unstalled: result appears two cycles after accept.
    send(64'hFFFF_0000_FFFF_0000, ones, 1'b0, 1'b0, 1'b0);
    idle();
    #4;
    chk("lat_n1_valid", 32'(out_valid_a), 0);
    @(negedge clk);
    #4;
    chk("lat_n2_valid", 32'(out_valid_a), 1);
    chk("lat_n2_count", 32'(count_a), 32);
    chk("lat_n2_ovf",   32'(ovf_a), 0);
    drain();

    // Zeros mode under a half mask.
    send(64'hFFFF_0000_FFFF_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    idle();
    drain();

    // Three-beat packet back-to-back; 192 saturates the 7-bit instance.
    send(ones, ones, 1'b0, 1'b1, 1'b0);
    send(ones, ones, 1'b0, 1'b1, 1'b0);
    send(ones, ones, 1'b0, 1'b1, 1'b1);
    // Overflow must not stick past the packet.
    send(64'h1, ones, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // last ignored while idle with accum_en low; accum_en low also closes a packet.
    send(64'hF, ones, 1'b0, 1'b0, 1'b1);
    send(64'hFF, ones, 1'b0, 1'b1, 1'b0);
    send(64'hF0F0, ones, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // Continuous stream with a five-cycle result stall in the middle.
    for (int i = 0; i < 12; i++) begin
      d = {$urandom, $urandom};
      send(d, ones, 1'b0, 1'b0, 1'b0);
      if (i == 3) stall_left = 5;
    end
    idle();
    drain();

    // Reset in the middle of a four-beat packet discards it.
    send(ones, ones, 1'b0, 1'b1, 1'b0);
    send(ones, ones, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_in_pkt = 1'b0;
    m_sum    = 0;
    @(negedge clk);
    rst = 1'b0;
    #4;
    check_reset_state("rst1");
    send(64'hFF, ones, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       m = ones;
        1:       m = '0;
        default: m = {$urandom, $urandom};
      endcase
      send(d, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    // Close any open packet so every beat produces a result.
    send(64'h3, ones, 1'b0, 1'b1, 1'b1);
    idle();
    rand_ready = 1'b0;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_state_idle", 32'(dbg_a), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
